// File: rtl/bank_switch_pkg.sv
// Shared types and constants for the multi-bank frame-buffer switch.
package bank_switch_pkg;
  typedef enum logic [1:0] {FREE, WRITING, READY, READING} bank_state_t;

  localparam int MODE_LATEST = 0;
  localparam int MODE_FIFO   = 1;
  localparam int MAX_BANKS   = 8;
  localparam int CNT_W       = 16;
endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser plus history flop; emits the synchronised level and a one-cycle rise pulse.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_hist;
  logic                   r_armed;

  // r_fill marks when r_sync holds real samples; r_armed needs a genuine low
  // first, so a level held high across reset never looks like a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_hist  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_hist  <= r_sync[SYNC_STAGES-1];
      r_armed <= r_armed | (r_fill[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-1]);
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_armed & r_sync[SYNC_STAGES-1] & ~r_hist;
endmodule

// File: rtl/multi_bank_switch.sv
// Frame-buffer bank arbiter between camera writer and VGA reader (LATEST or FIFO ordering).
// Optional statistics counters enabled by defining MULTI_BANK_STATS_EN.
module multi_bank_switch
  import bank_switch_pkg::*;
#(
  parameter  int NUM_BANKS   = 3,
  parameter  int MODE        = 0,
  parameter  int SYNC_STAGES = 2,
  localparam int BANK_W      = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst_133,
  input  logic              vga_rise,
  input  logic              cam_rise,
  input  logic              button,
  output logic [BANK_W-1:0] vga_bank,
  output logic [BANK_W-1:0] cam_bank,
  output logic [BANK_W-1:0] ready_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);
  localparam logic [BANK_W-1:0] LAST_PTR = BANK_W'(NUM_BANKS - 3);
  localparam logic [BANK_W-1:0] FULL_CNT = BANK_W'(NUM_BANKS - 2);

  logic w_vga_ev, w_cam_ev, w_btn, w_unused_vga_lvl, w_unused_cam_lvl, w_unused_btn_rise;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_vga_sync (
    .clk(clk), .rst(rst_133), .i_async(vga_rise), .o_level(w_unused_vga_lvl), .o_rise(w_vga_ev));
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_cam_sync (
    .clk(clk), .rst(rst_133), .i_async(cam_rise), .o_level(w_unused_cam_lvl), .o_rise(w_cam_ev));
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_btn_sync (
    .clk(clk), .rst(rst_133), .i_async(button), .o_level(w_btn), .o_rise(w_unused_btn_rise));

  bank_state_t       r_state [NUM_BANKS];
  logic [BANK_W-1:0] r_q     [NUM_BANKS];
  logic [BANK_W-1:0] r_wr, r_rd, r_cnt, r_vga, r_cam;

  bank_state_t       w_state [NUM_BANKS];
  logic [BANK_W-1:0] w_q     [NUM_BANKS];
  logic [BANK_W-1:0] w_wr, w_rd, w_cnt, w_vga, w_cam;
  logic              w_push;

  function automatic logic [BANK_W-1:0] ptr_inc(input logic [BANK_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Camera event resolved first; the reader then pops, so the bank it
  // releases cannot be picked as the next camera bank in the same cycle.
  always_comb begin
    w_state = r_state;
    w_q     = r_q;
    w_wr    = r_wr;
    w_rd    = r_rd;
    w_cnt   = r_cnt;
    w_vga   = r_vga;
    w_cam   = r_cam;
    w_push  = 1'b0;
    if (w_cam_ev) begin
      if (MODE == MODE_LATEST) begin
        if (w_cnt != '0) begin
          w_state[w_q[w_rd]] = FREE;
          w_rd  = ptr_inc(w_rd);
          w_cnt = w_cnt - 1'b1;
        end
        w_push = 1'b1;
      end else begin
        w_push = (w_cnt != FULL_CNT);
      end
      if (w_push) begin
        w_state[r_cam] = READY;
        w_q[w_wr]      = r_cam;
        w_wr           = ptr_inc(w_wr);
        w_cnt          = w_cnt + 1'b1;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
          if (w_state[i] == FREE) w_cam = BANK_W'(i);
        end
        w_state[w_cam] = WRITING;
      end
    end
    if (w_vga_ev && !w_btn && (w_cnt != '0)) begin
      w_state[r_vga] = FREE;
      w_vga          = w_q[w_rd];
      w_state[w_vga] = READING;
      w_rd           = ptr_inc(w_rd);
      w_cnt          = w_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_133) begin
    if (rst_133) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_state[i] <= (i == 0) ? READING : ((i == 1) ? WRITING : FREE);
        r_q[i]     <= '0;
      end
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_vga <= '0;
      r_cam <= BANK_W'(1);
    end else begin
      r_state <= w_state;
      r_q     <= w_q;
      r_wr    <= w_wr;
      r_rd    <= w_rd;
      r_cnt   <= w_cnt;
      r_vga   <= w_vga;
      r_cam   <= w_cam;
    end
  end

  assign vga_bank  = r_vga;
  assign cam_bank  = r_cam;
  assign ready_cnt = r_cnt;

`ifdef MULTI_BANK_STATS_EN
  logic             w_drop_inc, w_rep_inc;
  logic [CNT_W-1:0] r_drop, r_rep;

  // A reader start finds the queue empty only when no frame was pushed this cycle.
  assign w_drop_inc = w_cam_ev & ((MODE == MODE_LATEST) ? (r_cnt != '0) : (r_cnt == FULL_CNT));
  assign w_rep_inc  = w_vga_ev & ~w_btn & ~w_cam_ev & (r_cnt == '0);

  always_ff @(posedge clk or posedge rst_133) begin
    if (rst_133) begin
      r_drop <= '0;
      r_rep  <= '0;
    end else begin
      if (w_drop_inc && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      if (w_rep_inc && (r_rep != '1))   r_rep  <= r_rep + 1'b1;
    end
  end

  assign drop_cnt   = r_drop;
  assign repeat_cnt = r_rep;
`else
  assign drop_cnt   = '0;
  assign repeat_cnt = '0;
`endif
endmodule

// File: tb/tb_multi_bank_switch.sv
// Bench for multi_bank_switch: a 3-bank LATEST and a 5-bank FIFO instance share stimulus against a list-based model.
module tb_multi_bank_switch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vga_in = 1'b0, cam_in = 1'b0, btn_in = 1'b0;

  logic [1:0]  o3_vga, o3_cam, o3_rdy;
  logic [2:0]  o5_vga, o5_cam, o5_rdy;
  logic [15:0] o3_drop, o3_rep, o5_drop, o5_rep;

  int n_cmp = 0;
  int n_bad = 0;
  bit btn = 1'b0;

  // Model state: [0] = 3 banks LATEST, [1] = 5 banks FIFO.
  int m_vga [2];
  int m_cam [2];
  int m_q   [2][8];
  int m_len [2];
  int m_drop[2];
  int m_rep [2];

  always #5 clk = ~clk;

  multi_bank_switch #(.NUM_BANKS(3), .MODE(0), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rst_133(rst), .vga_rise(vga_in), .cam_rise(cam_in), .button(btn_in),
    .vga_bank(o3_vga), .cam_bank(o3_cam), .ready_cnt(o3_rdy), .drop_cnt(o3_drop), .repeat_cnt(o3_rep));

  multi_bank_switch #(.NUM_BANKS(5), .MODE(1), .SYNC_STAGES(2)) dut5 (
    .clk(clk), .rst_133(rst), .vga_rise(vga_in), .cam_rise(cam_in), .button(btn_in),
    .vga_bank(o5_vga), .cam_bank(o5_cam), .ready_cnt(o5_rdy), .drop_cnt(o5_drop), .repeat_cnt(o5_rep));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vga[k] = 0; m_cam[k] = 1; m_len[k] = 0; m_drop[k] = 0; m_rep[k] = 0;
    end
  endtask

  function automatic int lowest_free(input int k);
    int n = (k == 0) ? 3 : 5;
    for (int b = 0; b < n; b++) begin
      bit taken = (b == m_cam[k]) || (b == m_vga[k]);
      for (int j = 0; j < m_len[k]; j++) if (m_q[k][j] == b) taken = 1'b1;
      if (!taken) return b;
    end
    return -1;
  endfunction

  task automatic model_step(input bit c, input bit v, input bit b);
    for (int k = 0; k < 2; k++) begin
      int depth = (k == 0) ? 1 : 3;
      if (c) begin
        if (k == 0 && m_len[k] > 0) begin
          m_len[k] = 0;
          if (m_drop[k] < 65535) m_drop[k]++;
        end
        if (m_len[k] < depth) begin
          m_q[k][m_len[k]] = m_cam[k];
          m_len[k]++;
          m_cam[k] = lowest_free(k);
        end else if (m_drop[k] < 65535) begin
          m_drop[k]++;
        end
      end
      if (v && !b) begin
        if (m_len[k] > 0) begin
          m_vga[k] = m_q[k][0];
          for (int j = 1; j < m_len[k]; j++) m_q[k][j-1] = m_q[k][j];
          m_len[k]--;
        end else if (m_rep[k] < 65535) begin
          m_rep[k]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int e3d, e3r, e5d, e5r;
`ifdef MULTI_BANK_STATS_EN
    e3d = m_drop[0]; e3r = m_rep[0]; e5d = m_drop[1]; e5r = m_rep[1];
`else
    e3d = 0; e3r = 0; e5d = 0; e5r = 0;
`endif
    chk({tag, "_vga3"},  int'(o3_vga),  m_vga[0]);
    chk({tag, "_cam3"},  int'(o3_cam),  m_cam[0]);
    chk({tag, "_rdy3"},  int'(o3_rdy),  m_len[0]);
    chk({tag, "_drop3"}, int'(o3_drop), e3d);
    chk({tag, "_rep3"},  int'(o3_rep),  e3r);
    chk({tag, "_vga5"},  int'(o5_vga),  m_vga[1]);
    chk({tag, "_cam5"},  int'(o5_cam),  m_cam[1]);
    chk({tag, "_rdy5"},  int'(o5_rdy),  m_len[1]);
    chk({tag, "_drop5"}, int'(o5_drop), e5d);
    chk({tag, "_rep5"},  int'(o5_rep),  e5r);
  endtask

  task automatic do_event(input string tag, input bit c, input bit v);
    @(negedge clk);
    cam_in = c;
    vga_in = v;
    repeat (4) @(negedge clk);
    model_step(c, v, btn);
    check_all(tag);
    cam_in = 1'b0;
    vga_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_button(input bit b);
    @(negedge clk);
    btn_in = b;
    btn = b;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all("rst0");
    chk("rst0_cam3_const", int'(o3_cam), 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single frame then read; then two frames before one read.
    do_event("t2_cam", 1'b1, 1'b0);
    do_event("t2_vga", 1'b0, 1'b1);
    do_event("t3_cam_a", 1'b1, 1'b0);
    do_event("t3_cam_b", 1'b1, 1'b0);
    do_event("t3_vga", 1'b0, 1'b1);

    // Fill the FIFO queue, overflow it, drain it in order.
    do_reset("t4_rst");
    for (int i = 0; i < 4; i++) do_event("t4_cam", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_event("t4_vga", 1'b0, 1'b1);
    chk("t4_vga5_const", int'(o5_vga), 3);

    // Same-cycle writer and reader events straight after reset.
    do_reset("t5_rst");
    do_event("t5_both", 1'b1, 1'b1);
    chk("t5_vga3_const", int'(o3_vga), 1);
    chk("t5_cam3_const", int'(o3_cam), 2);

    // Frozen display ignores reader starts; unfrozen empty queue repeats.
    set_button(1'b1);
    do_event("t6_frz_a", 1'b0, 1'b1);
    do_event("t6_frz_b", 1'b0, 1'b1);
    do_event("t6_frz_cam", 1'b1, 1'b0);
    do_event("t6_frz_c", 1'b0, 1'b1);
    set_button(1'b0);
    do_event("t6_vga", 1'b0, 1'b1);
    do_event("t6_rep", 1'b0, 1'b1);

    // Reset mid-frame with the writer input held high: no event after release.
    do_event("t7_pre", 1'b1, 1'b0);
    @(negedge clk);
    cam_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t7_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_all("t7_held");
    cam_in = 1'b0;
    repeat (4) @(negedge clk);
    do_event("t7_post", 1'b1, 1'b0);

    for (int it = 0; it < 150; it++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) begin
        set_button(~btn);
      end else if (r == 1) begin
        do_reset("rnd_rst");
      end else begin
        bit c = 1'(($urandom_range(0, 1)));
        bit v = 1'(($urandom_range(0, 1)));
        if (c || v) do_event("rnd", c, v);
      end
    end
    set_button(1'b0);
    do_event("end_vga", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
